// File: rtl/dcm_pkg.sv
// dcm_pkg: register map, flag bits and FSM encodings shared by the loop scheduler.
package dcm_pkg;
  localparam int NUM_CH = 8;

  // Status block at 8n (flags, pos[23:16], pos[15:8], pos[7:0]);
  // control block at 64+8n (speed, tgt[23:16], tgt[15:8], tgt[7:0]).
  localparam logic [6:0] STAT_BASE = 7'd0;
  localparam logic [6:0] CTL_BASE  = 7'd64;

  localparam int FL_EN    = 0;
  localparam int FL_DIR   = 1;
  localparam int FL_AT    = 2;
  localparam int FL_FAULT = 3;
  localparam int FL_OTW   = 4;
  localparam int FL_RTY   = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EVAL  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  // Fetch order: 0 speed, 1..3 target bytes (MSB first), 4..6 position bytes.
  localparam logic [2:0] FETCH_LAST = 3'd6;

  function automatic logic [6:0] fetch_addr(input logic [2:0] ch, input logic [2:0] idx);
    if (idx <= 3'd3) return CTL_BASE | {1'b0, ch, idx};
    else             return STAT_BASE | {1'b0, ch, idx - 3'd3};
  endfunction
endpackage

// File: rtl/dcm_chan_eval.sv
// dcm_chan_eval: combinational per-channel decision (enable, direction, duty).
// One instance is time-shared across all channels by the scheduler.
module dcm_chan_eval #(
  parameter int DEADBAND = 2
) (
  input  logic [7:0]  speed,
  input  logic [23:0] tgt,
  input  logic [23:0] cur,
  input  logic        fault,
  input  logic        otw,
  output logic        en,
  output logic        dir,
  output logic        at_target,
  output logic [7:0]  duty
);
  logic [23:0] mag;

  // Unsigned distance to target, then fault > at-target > drive priority
  always_comb begin
    mag       = (tgt > cur) ? (tgt - cur) : (cur - tgt);
    en        = 1'b0;
    dir       = 1'b0;
    at_target = 1'b0;
    duty      = 8'd0;
    if (fault || otw) begin
      en = 1'b0;
    end else if (speed == 8'd0 || mag <= 24'(DEADBAND)) begin
      at_target = 1'b1;
    end else begin
      en   = 1'b1;
      dir  = (tgt > cur);
      duty = (mag < {16'd0, speed}) ? mag[7:0] : speed;
    end
  end
endmodule

// File: rtl/dcm_loop_sched.sv
// dcm_loop_sched: round-robin control-loop scheduler for 8 DC motor channels.
// Optional feature macro: DCM_FAULT_RETRY_EN (motor_reset pulse + retry count).
module dcm_loop_sched
  import dcm_pkg::*;
#(
  parameter int SWEEP_DIV = 1000,
  parameter int DEADBAND  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rf_req,
  input  logic        rf_gnt,
  output logic [6:0]  rf_addr,
  output logic        rf_wen,
  output logic [7:0]  rf_wdata,
  input  logic [7:0]  rf_rdata,
  input  logic [7:0]  motor_fault,
  input  logic [7:0]  motor_otw,
  output logic [7:0]  drv_en,
  output logic [7:0]  drv_dir,
  output logic [63:0] drv_duty,
  output logic [7:0]  motor_reset,
  output logic        sweep_done,
  output logic        overrun
);
  localparam int CW = $clog2(SWEEP_DIV);

  logic [1:0]      state_q, state_d;
  logic [2:0]      ch_q, ch_d, idx_q, idx_d, cap_idx_q, cap_idx_d;
  logic            cap_vld_q, cap_vld_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      spd_q, spd_d, flags_q, flags_d;
  logic [23:0]     tgt_q, tgt_d, cur_q, cur_d;
  logic [7:0]      en_q, en_d, dir_q, dir_d;
  logic [7:0][7:0] duty_q, duty_d;
  logic            done_q, done_d, ovr_q, ovr_d;
  logic [7:0]      mrst_q, mrst_d;
  logic [7:0][2:0] rty_q, rty_d;
  logic            tick;
  logic            ev_en, ev_dir, ev_at;
  logic [7:0]      ev_duty;

  assign tick = (cnt_q == CW'(SWEEP_DIV - 1));

  // Merge read data returned this cycle; the last byte lands during EVAL,
  // so the evaluator works from these merged values rather than the flops.
  always_comb begin
    spd_d = spd_q;
    tgt_d = tgt_q;
    cur_d = cur_q;
    if (cap_vld_q) begin
      case (cap_idx_q)
        3'd0:    spd_d         = rf_rdata;
        3'd1:    tgt_d[23:16]  = rf_rdata;
        3'd2:    tgt_d[15:8]   = rf_rdata;
        3'd3:    tgt_d[7:0]    = rf_rdata;
        3'd4:    cur_d[23:16]  = rf_rdata;
        3'd5:    cur_d[15:8]   = rf_rdata;
        default: cur_d[7:0]    = rf_rdata;
      endcase
    end
  end

  dcm_chan_eval #(.DEADBAND(DEADBAND)) u_eval (
    .speed(spd_d), .tgt(tgt_d), .cur(cur_d),
    .fault(motor_fault[ch_q]), .otw(motor_otw[ch_q]),
    .en(ev_en), .dir(ev_dir), .at_target(ev_at), .duty(ev_duty)
  );

  // Sweep timer, FSM sequencing and per-channel drive/status update
  always_comb begin
    logic [2:0] rty_nxt;
    rty_nxt   = 3'd0;
    state_d   = state_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cap_idx_q;
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    flags_d   = flags_q;
    en_d      = en_q;
    dir_d     = dir_q;
    duty_d    = duty_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q | (tick && state_q != ST_IDLE);
    mrst_d    = mrst_q;
    rty_d     = rty_q;
    case (state_q)
      ST_IDLE: if (tick) begin
        state_d = ST_FETCH;
        ch_d    = 3'd0;
        idx_d   = 3'd0;
      end
      ST_FETCH: if (rf_gnt) begin
        cap_vld_d = 1'b1;
        cap_idx_d = idx_q;
        if (idx_q == FETCH_LAST) state_d = ST_EVAL;
        else                     idx_d   = idx_q + 3'd1;
      end
      ST_EVAL: begin
`ifdef DCM_FAULT_RETRY_EN
        if (motor_fault[ch_q]) begin
          rty_nxt      = (rty_q[ch_q] == 3'd7) ? 3'd7 : rty_q[ch_q] + 3'd1;
          mrst_d[ch_q] = 1'b1;
        end else begin
          rty_nxt      = 3'd0;
          mrst_d[ch_q] = 1'b0;
        end
        rty_d[ch_q] = rty_nxt;
`endif
        en_d[ch_q]   = ev_en;
        dir_d[ch_q]  = ev_dir;
        duty_d[ch_q] = ev_duty;
        flags_d      = {rty_nxt, motor_otw[ch_q], motor_fault[ch_q], ev_at, ev_dir, ev_en};
        state_d      = ST_WB;
      end
      default: if (rf_gnt) begin
        if (ch_q == 3'(NUM_CH - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          ch_d    = ch_q + 3'd1;
          idx_d   = 3'd0;
          state_d = ST_FETCH;
        end
      end
    endcase
  end

  // State registers; reset aborts any sweep in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;  ch_q <= '0;     idx_q <= '0;
      cap_vld_q <= 1'b0;   cap_idx_q <= '0; cnt_q <= '0;
      spd_q <= '0;         tgt_q <= '0;    cur_q <= '0;   flags_q <= '0;
      en_q <= '0;          dir_q <= '0;    duty_q <= '0;
      done_q <= 1'b0;      ovr_q <= 1'b0;  mrst_q <= '0;  rty_q <= '0;
    end else begin
      state_q <= state_d;  ch_q <= ch_d;   idx_q <= idx_d;
      cap_vld_q <= cap_vld_d; cap_idx_q <= cap_idx_d; cnt_q <= cnt_d;
      spd_q <= spd_d;      tgt_q <= tgt_d; cur_q <= cur_d; flags_q <= flags_d;
      en_q <= en_d;        dir_q <= dir_d; duty_q <= duty_d;
      done_q <= done_d;    ovr_q <= ovr_d; mrst_q <= mrst_d; rty_q <= rty_d;
    end
  end

  assign rf_req     = (state_q == ST_FETCH) || (state_q == ST_WB);
  assign rf_wen     = (state_q == ST_WB);
  assign rf_wdata   = (state_q == ST_WB) ? flags_q : 8'd0;
  assign rf_addr    = (state_q == ST_FETCH) ? fetch_addr(ch_q, idx_q) :
                      (state_q == ST_WB)    ? (STAT_BASE | {1'b0, ch_q, 3'd0}) : 7'd0;
  assign drv_en     = en_q;
  assign drv_dir    = dir_q;
  assign drv_duty   = duty_q;
  assign sweep_done = done_q;
  assign overrun    = ovr_q;
`ifdef DCM_FAULT_RETRY_EN
  assign motor_reset = mrst_q;
`else
  assign motor_reset = 8'd0;
`endif
endmodule

// File: tb/tb_dcm_loop_sched.sv
// tb_dcm_loop_sched: directed checks of the loop scheduler against a byte-array
// register file model. Honours DCM_FAULT_RETRY_EN for the fault expectations.
module tb_dcm_loop_sched;
  localparam int SWEEP_DIV = 81;
`ifdef DCM_FAULT_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1, rf_gnt = 1'b1;
  logic        rf_req, rf_wen, sweep_done, overrun;
  logic [6:0]  rf_addr;
  logic [7:0]  rf_wdata, rf_rdata = 8'd0;
  logic [7:0]  motor_fault = 8'd0, motor_otw = 8'd0;
  logic [7:0]  drv_en, drv_dir, motor_reset;
  logic [63:0] drv_duty;

  logic [7:0]  mem [0:127];
  logic [7:0]  flg [0:7];
  int          wr_count = 0;
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, t0 = 0, last_len = 0;
  bit          in_sw = 1'b0;

  dcm_loop_sched #(.SWEEP_DIV(SWEEP_DIV), .DEADBAND(2)) dut (
    .clk(clk), .reset(reset), .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_addr(rf_addr),
    .rf_wen(rf_wen), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .motor_fault(motor_fault), .motor_otw(motor_otw), .drv_en(drv_en),
    .drv_dir(drv_dir), .drv_duty(drv_duty), .motor_reset(motor_reset),
    .sweep_done(sweep_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Register file model: 1-cycle read latency, flag writes land in flg[]
  always @(posedge clk) begin
    if (rf_req && rf_gnt) begin
      if (rf_wen) begin
        flg[rf_addr[5:3]] <= rf_wdata;
        wr_count <= wr_count + 1;
      end
      rf_rdata <= mem[rf_addr];
    end
  end

  // Sweep length monitor: first request cycle to sweep_done cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) in_sw = 1'b0;
    else begin
      if (rf_req && !in_sw) begin in_sw = 1'b1; t0 = cyc; end
      if (sweep_done) begin in_sw = 1'b0; last_len = cyc - t0; end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] spd, input logic [23:0] tgt, input logic [23:0] cur);
    mem[64 + 8*ch] = spd;
    mem[65 + 8*ch] = tgt[23:16]; mem[66 + 8*ch] = tgt[15:8]; mem[67 + 8*ch] = tgt[7:0];
    mem[1 + 8*ch]  = cur[23:16]; mem[2 + 8*ch]  = cur[15:8];  mem[3 + 8*ch]  = cur[7:0];
  endtask

  // Count negedges until rf_req rises (bounded)
  task automatic wait_start(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rf_req && n < 300);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!sweep_done && n < 400);
    if (!sweep_done) chk({tag, "_timeout"}, 64'(sweep_done), 64'd1);
    #1;
  endtask

  logic [7:0] exp_fl [0:7];
  int n, dn, wc;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'd0;
    for (int i = 0; i < 8; i++) flg[i] = 8'd0;
    set_ch(0, 8'd100, 24'd200, 24'd0);
    set_ch(1, 8'd50,  24'h000100, 24'h000300);
    set_ch(2, 8'd255, 24'h010000, 24'd0);
    set_ch(3, 8'd50,  24'd100, 24'd0);
    set_ch(4, 8'd10,  24'd5, 24'd3);
    set_ch(5, 8'd10,  24'd5, 24'd2);
    set_ch(6, 8'd9,   24'h800000, 24'h7FFFFF);
    set_ch(7, 8'd0,   24'd100, 24'd0);
    exp_fl = '{8'h03, 8'h01, 8'h03, 8'h03, 8'h04, 8'h03, 8'h04, 8'h04};

    repeat (3) @(negedge clk);
    chk("rst_drv_en", 64'(drv_en), 64'd0);
    chk("rst_duty", drv_duty, 64'd0);
    chk("rst_req", 64'({rf_req, rf_wen, sweep_done, overrun}), 64'd0);
    reset = 1'b0;
    wait_start(n);
    chk("first_sweep_delay", 64'(n), 64'(SWEEP_DIV));

    // Sweep 1: mixed channels incl. deadband boundary and saturation
    wait_done("sweep1");
    chk("sweep1_len", 64'(last_len), 64'd72);
    for (int i = 0; i < 8; i++) chk($sformatf("sweep1_flags_ch%0d", i), 64'(flg[i]), 64'(exp_fl[i]));
    chk("sweep1_en", 64'(drv_en), 64'h2F);
    chk("sweep1_dir", 64'(drv_dir), 64'h2D);
    chk("duty_ch0", 64'(drv_duty[7:0]), 64'd100);
    chk("duty_ch1", 64'(drv_duty[15:8]), 64'd50);
    chk("duty_ch2", 64'(drv_duty[23:16]), 64'd255);
    chk("duty_ch5", 64'(drv_duty[47:40]), 64'd3);
    chk("sweep1_overrun", 64'(overrun), 64'd0);

    // Sweep 2/3: ch0 closer to target, then inside deadband
    set_ch(0, 8'd100, 24'd200, 24'd150);
    wait_done("sweep2");
    chk("s2_duty_ch0", 64'(drv_duty[7:0]), 64'd50);
    chk("s2_flags_ch0", 64'(flg[0]), 64'h03);
    set_ch(0, 8'd100, 24'd200, 24'd199);
    wait_done("sweep3");
    chk("s3_en_ch0", 64'(drv_en[0]), 64'd0);
    chk("s3_flags_ch0", 64'(flg[0]), 64'h04);
    chk("s3_duty_ch0", 64'(drv_duty[7:0]), 64'd0);

    // Sweep 4: grant withheld 5 cycles during ch0 fetch
    set_ch(0, 8'd120, 24'd200, 24'd100);
    wait_start(n);
    repeat (2) @(negedge clk);
    chk("stall_addr0", 64'(rf_addr), 64'd66);
    rf_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d", i), 64'(rf_addr), 64'd66);
    end
    rf_gnt = 1'b1;
    wait_done("sweep4");
    chk("stall_len", 64'(last_len), 64'd77);
    chk("stall_duty_ch0", 64'(drv_duty[7:0]), 64'd100);
    chk("stall_flags_ch0", 64'(flg[0]), 64'h03);

    // Sweeps 5-7: fault on ch3, otw on ch5, then both cleared
    motor_fault[3] = 1'b1;
    motor_otw[5]   = 1'b1;
    wait_done("sweep5");
    chk("fault_en3", 64'(drv_en[3]), 64'd0);
    chk("fault_flags3", 64'(flg[3]), RETRY ? 64'h28 : 64'h08);
    chk("fault_mreset", 64'(motor_reset), RETRY ? 64'h08 : 64'h00);
    chk("otw_flags5", 64'(flg[5]), 64'h10);
    chk("otw_en5", 64'(drv_en[5]), 64'd0);
    wait_done("sweep6");
    chk("fault2_flags3", 64'(flg[3]), RETRY ? 64'h48 : 64'h08);
    chk("fault2_mreset", 64'(motor_reset), RETRY ? 64'h08 : 64'h00);
    motor_fault[3] = 1'b0;
    motor_otw[5]   = 1'b0;
    wait_done("sweep7");
    chk("recover_flags3", 64'(flg[3]), 64'h03);
    chk("recover_en3", 64'(drv_en[3]), 64'd1);
    chk("recover_mreset", 64'(motor_reset), 64'd0);
    chk("recover_flags5", 64'(flg[5]), 64'h03);

    // Grant every other cycle: sweeps outlast SWEEP_DIV
    chk("pre_overrun", 64'(overrun), 64'd0);
    dn = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rf_gnt = ~rf_gnt;
      if (sweep_done) dn++;
    end
    rf_gnt = 1'b1;
    chk("slow_sweeps_done", 64'(dn >= 2), 64'd1);
    wait_done("slow_tail");
    chk("overrun_set", 64'(overrun), 64'd1);
    chk("slow_flags_ch0", 64'(flg[0]), 64'h03);

    // Reset during channel 4 fetch
    wait_start(n);
    repeat (38) @(negedge clk);
    chk("ch4_fetch_addr", 64'(rf_addr), 64'd98);
    wc = wr_count;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_drv", 64'({drv_en, drv_dir, motor_reset}), 64'd0);
    chk("midrst_duty", drv_duty, 64'd0);
    chk("midrst_rf", 64'({rf_req, rf_wen, rf_addr, rf_wdata}), 64'd0);
    chk("midrst_flags", 64'({sweep_done, overrun}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_start(n);
    chk("restart_delay", 64'(n), 64'(SWEEP_DIV));
    chk("no_partial_write", 64'(wr_count), 64'(wc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcm_loop_sched.md
# dcm_loop_sched

Round-robin control-loop scheduler for the 8-channel DC motor controller. On every sweep tick it visits channels 0..7 in turn. For each channel it fetches target speed, target position and current position from the shared 128-byte register file, decides drive enable, direction and duty, and writes a status flags byte back. It sits between the SPI register file (as a secondary requester with grant handshake) and the per-channel PWM/bridge drivers.

## Interface
- SWEEP_DIV, 1000: clk cycles between sweep starts; must be >= 81
- DEADBAND, 2: |target-current| <= DEADBAND counts as at target
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rf_req  out  1  scheduler requests register file
- rf_gnt  in  1  register file granted this cycle (SPI has priority)
- rf_addr  out  7  byte address
- rf_wen  out  1  write strobe, valid only with rf_gnt
- rf_wdata  out  8  write data
- rf_rdata  in  8  read data, 1-cycle latency after addr with gnt
- motor_fault  in  8  per-channel fault, active-high
- motor_otw  in  8  per-channel over-temperature warning
- drv_en  out  8  bridge enable per channel
- drv_dir  out  8  1 = move toward larger position
- drv_duty  out  64  8 x 8-bit duty, channel n at [8n+7:8n]
- motor_reset  out  8  driver reset pulse per channel
- sweep_done  out  1  one-cycle pulse after channel 7 writeback
- overrun  out  1  sticky: tick arrived while a sweep was active

## Operation
- Map: status of channel n at 8n (flags, pos[23:16], [15:8], [7:0]); control at 64+8n (speed, tgt[23:16], [15:8], [7:0]).
- States: IDLE -> FETCH (7 reads: speed, tgt x3, cur x3) -> EVAL -> WB (write flags to 8n) -> FETCH for next channel, or IDLE after channel 7.
- rf_req is high in FETCH/WB. An access only counts in a cycle with rf_gnt. If gnt is low, hold the address and state and reissue. Capture data only for granted addresses.
- EVAL, unsigned 24-bit: err = tgt - cur; mag = |err|.
  - fault or otw: en=0.
  - else speed==0 or mag<=DEADBAND: en=0, at_target=1.
  - else en=1, dir=(tgt>cur), duty=min(speed, mag) (saturating, 8 bit).
- Flags: b0 en, b1 dir, b2 at_target, b3 fault, b4 otw, b7:5 retry count.
- Drive outputs for channel n change only at the end of its EVAL. Other channels hold their values.

## Timing
- Reset: every output 0, state IDLE, tick counter 0, retry counts 0. The first sweep starts SWEEP_DIV cycles after reset deasserts.
- Per channel with gnt held high: 7 fetch + 1 EVAL + 1 WB = 9 cycles; sweep = 72 cycles. sweep_done fires the cycle after channel 7's WB.
- Tick while not IDLE: set overrun and drop the tick. The tick counter keeps running.
- Reset mid-sweep: abort. All outputs are 0 at the next edge, and no partial write is issued.
- Fault and otw are sampled in EVAL only.

## Configuration
- DCM_FAULT_RETRY_EN defined: a faulted channel gets motor_reset[n] high from its EVAL through its next EVAL (one sweep). Its retry count increments, saturating at 7. Retry count clears on the first fault-free EVAL.
- Not defined: motor_reset is constantly 0 and flags b7:5 read 0. The channel recovers automatically once the fault clears.

## Structure
- dcm_pkg: register map offsets, flag bit indices, state enum, NUM_CH=8.
- Sub-module dcm_chan_eval: combinational compare/duty/flags from speed, tgt, cur, fault, otw. It is instantiated once and shared across channels.

## Test plan
- Channel 0: speed=100, tgt=200, cur=0 -> after its EVAL, en=1, dir=1, duty=100, flags written to addr 0 = 0x03.
- Channel 0: speed=100, tgt=200, cur=150 -> duty=50. cur=199 -> en=0, at_target=1, flags=0x04.
- rf_gnt low for 5 cycles mid-FETCH -> same address reissued, fetched values correct, sweep lengthened by exactly 5 cycles.
- motor_fault[3]=1 -> drv_en[3]=0, flags at 24 = 0x08 (macro off). With macro on, motor_reset[3] high for one sweep and retry count increments.
- SWEEP_DIV=81 with gnt toggling every other cycle -> overrun set, ticks dropped, sweeps still complete.
- Reset asserted during channel 4 FETCH -> next edge all outputs 0, no rf_wen, and the first sweep restarts SWEEP_DIV cycles after release.
